// File: rtl/doomsday_input_ctrl.sv
// Button conditioner and mode sequencer: synchronises and debounces three raw buttons,
// then drives one-hot mode levels, run levels and auto-repeating increase pulses.
module doomsday_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_mode,
    input  logic btn_go,
    input  logic btn_inc,
    output logic countup,
    output logic countdown,
    output logic timerset,
    output logic timercount,
    output logic alarmset,
    output logic alarmcount,
    output logic increase
);

    localparam int NBTN = 3;
    localparam int B_MODE = 0;
    localparam int B_GO   = 1;
    localparam int B_INC  = 2;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_CLOCK,
        S_UP,
        S_DOWN,
        S_TIMER,
        S_ALARM
    } state_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1_reg;
    logic [NBTN-1:0] sync2_reg;
    logic [NBTN-1:0] stable_reg;
    logic [NBTN-1:0] press;

    assign raw = {btn_inc, btn_go, btn_mode};

    // The press strobe fires on the cycle the debouncer accepts a rising input, so the
    // registered outputs react on the same edge that stable_reg updates.
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [CNT_W-1:0] db_cnt_reg;
            logic             accept;

            assign accept    = (sync2_reg[gi] != stable_reg[gi]) && (db_cnt_reg == DB_LAST);
            assign press[gi] = accept && sync2_reg[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg[gi]  <= 1'b0;
                    sync2_reg[gi]  <= 1'b0;
                    stable_reg[gi] <= 1'b0;
                    db_cnt_reg     <= '0;
                end else begin
                    sync1_reg[gi] <= raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    if (sync2_reg[gi] == stable_reg[gi]) begin
                        db_cnt_reg <= '0;
                    end else if (accept) begin
                        stable_reg[gi] <= sync2_reg[gi];
                        db_cnt_reg     <= '0;
                    end else if (db_cnt_reg != CNT_MAX) begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    state_t           state_reg, state_next;
    logic             run_reg, run_next;
    logic             rpt_active_reg, rpt_active_next;
    logic             rpt_first_reg, rpt_first_next;
    logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             increase_next;
    logic             set_mode;
    logic             inc_allowed;
    logic [CNT_W-1:0] rpt_last;

    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        rpt_active_next = rpt_active_reg;
        rpt_first_next  = rpt_first_reg;
        rpt_cnt_next    = rpt_cnt_reg;
        increase_next   = 1'b0;

        set_mode    = (state_reg == S_TIMER) || (state_reg == S_ALARM);
        inc_allowed = set_mode && !run_reg;
        rpt_last    = rpt_first_reg ? DELAY_LAST : PERIOD_LAST;

        if (press[B_MODE]) begin
            unique case (state_reg)
                S_CLOCK: state_next = S_UP;
                S_UP:    state_next = S_DOWN;
                S_DOWN:  state_next = S_TIMER;
                S_TIMER: state_next = S_ALARM;
                default: state_next = S_CLOCK;
            endcase
            run_next        = 1'b0;
            rpt_active_next = 1'b0;
            rpt_cnt_next    = '0;
        end else if (press[B_GO]) begin
            // A go press also swallows any inc event in the same cycle.
            if (set_mode) begin
                run_next        = !run_reg;
                rpt_active_next = 1'b0;
                rpt_cnt_next    = '0;
            end
        end else if (press[B_INC] && inc_allowed) begin
            increase_next   = 1'b1;
            rpt_active_next = 1'b1;
            rpt_first_next  = 1'b1;
            rpt_cnt_next    = '0;
        end else if (rpt_active_reg) begin
            if (!stable_reg[B_INC] || !inc_allowed) begin
                rpt_active_next = 1'b0;
                rpt_cnt_next    = '0;
            end else if (rpt_cnt_reg == rpt_last) begin
                increase_next  = 1'b1;
                rpt_first_next = 1'b0;
                rpt_cnt_next   = '0;
            end else if (rpt_cnt_reg != CNT_MAX) begin
                rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_CLOCK;
            run_reg        <= 1'b0;
            rpt_active_reg <= 1'b0;
            rpt_first_reg  <= 1'b0;
            rpt_cnt_reg    <= '0;
            countup        <= 1'b0;
            countdown      <= 1'b0;
            timerset       <= 1'b0;
            timercount     <= 1'b0;
            alarmset       <= 1'b0;
            alarmcount     <= 1'b0;
            increase       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_reg        <= run_next;
            rpt_active_reg <= rpt_active_next;
            rpt_first_reg  <= rpt_first_next;
            rpt_cnt_reg    <= rpt_cnt_next;
            countup        <= (state_next == S_UP);
            countdown      <= (state_next == S_DOWN);
            timerset       <= (state_next == S_TIMER);
            timercount     <= (state_next == S_TIMER) && run_next;
            alarmset       <= (state_next == S_ALARM);
            alarmcount     <= (state_next == S_ALARM) && run_next;
            increase       <= increase_next;
        end
    end

endmodule

// File: tb/tb_doomsday_input_ctrl.sv
// Directed bench for doomsday_input_ctrl with short debounce/repeat parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_doomsday_input_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic btn_mode, btn_go, btn_inc;
    logic countup, countdown, timerset, timercount, alarmset, alarmcount, increase;

    int total = 0;
    int bad   = 0;

    // {countup, countdown, timerset, timercount, alarmset, alarmcount, increase}
    localparam logic [6:0] O_CLOCK = 7'b0000000;
    localparam logic [6:0] O_UP    = 7'b1000000;
    localparam logic [6:0] O_DOWN  = 7'b0100000;
    localparam logic [6:0] O_TIMER = 7'b0010000;
    localparam logic [6:0] O_TRUN  = 7'b0011000;
    localparam logic [6:0] O_ALARM = 7'b0000100;

    doomsday_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (4),
        .CNT_W          (25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_go    (btn_go),
        .btn_inc   (btn_inc),
        .countup   (countup),
        .countdown (countdown),
        .timerset  (timerset),
        .timercount(timercount),
        .alarmset  (alarmset),
        .alarmcount(alarmcount),
        .increase  (increase)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {countup, countdown, timerset, timercount, alarmset, alarmcount, increase};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press: held 10 cycles, then released for 10 cycles.
    task automatic press_mode();
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_mode = 1'b0;
        btn_go = 1'b0;
        btn_inc = 1'b0;
        tick(3);
        total++;
        if (outs() !== O_CLOCK) begin
            bad++;
            $display("FAIL reset_outs: got %b want %b", outs(), O_CLOCK);
        end
        reset = 1'b0;
        tick(2);
        $display("txn reset outs=%b", outs());
    endtask

    task automatic test_mode_cycle();
        logic [6:0] exp_seq [5];
        exp_seq[0] = O_UP;
        exp_seq[1] = O_DOWN;
        exp_seq[2] = O_TIMER;
        exp_seq[3] = O_ALARM;
        exp_seq[4] = O_CLOCK;
        for (int p = 0; p < 5; p++) begin
            btn_mode = 1'b1;
            tick(5);
            total++;
            if (outs() !== exp_seq[(p + 4) % 5]) begin
                bad++;
                $display("FAIL mode_latency_%0d: got %b want %b", p, outs(), exp_seq[(p + 4) % 5]);
            end
            tick(1);
            total++;
            if (outs() !== exp_seq[p]) begin
                bad++;
                $display("FAIL mode_step_%0d: got %b want %b", p, outs(), exp_seq[p]);
            end
            tick(4);
            btn_mode = 1'b0;
            tick(10);
            $display("txn mode_press %0d outs=%b", p, outs());
        end
    endtask

    task automatic test_go_bounce();
        press_mode();
        press_mode();
        press_mode();
        total++;
        if (outs() !== O_TIMER) begin
            bad++;
            $display("FAIL go_setup_timer: got %b want %b", outs(), O_TIMER);
        end
        btn_go = 1'b1; tick(1);
        btn_go = 1'b0; tick(1);
        btn_go = 1'b1; tick(1);
        btn_go = 1'b0; tick(1);
        btn_go = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++;
            if (timercount !== (k >= 6)) begin
                bad++;
                $display("FAIL go_bounce_t%0d: timercount=%b want %b", k, timercount, (k >= 6));
            end
        end
        btn_go = 1'b0;
        tick(12);
        total++;
        if (outs() !== O_TRUN) begin
            bad++;
            $display("FAIL go_single_toggle: got %b want %b", outs(), O_TRUN);
        end
        $display("txn go_bounce outs=%b", outs());
    endtask

    task automatic test_auto_repeat();
        int pulses_late;
        press_mode();
        total++;
        if (outs() !== O_ALARM) begin
            bad++;
            $display("FAIL rpt_setup_alarm: got %b want %b", outs(), O_ALARM);
        end
        btn_inc = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            logic want;
            tick(1);
            want = (t == 6) || (t == 22) || (t == 26) || (t == 30) || (t == 34) || (t == 38);
            total++;
            if (increase !== want) begin
                bad++;
                $display("FAIL rpt_pulse_t%0d: increase=%b want %b", t, increase, want);
            end
        end
        btn_inc = 1'b0;
        tick(6);
        pulses_late = 0;
        for (int t = 47; t <= 70; t++) begin
            tick(1);
            if (increase === 1'b1) pulses_late++;
        end
        total++;
        if (pulses_late != 0) begin
            bad++;
            $display("FAIL rpt_after_release: pulses=%0d want 0", pulses_late);
        end
        $display("txn auto_repeat late_pulses=%0d", pulses_late);
    endtask

    task automatic test_inc_blocked_when_running();
        int pulses;
        press_mode();
        press_mode();
        press_mode();
        press_mode();
        btn_go = 1'b1;
        tick(10);
        btn_go = 1'b0;
        tick(10);
        total++;
        if (outs() !== O_TRUN) begin
            bad++;
            $display("FAIL blk_setup_run: got %b want %b", outs(), O_TRUN);
        end
        pulses = 0;
        btn_inc = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick(1);
            if (increase === 1'b1) pulses++;
        end
        btn_inc = 1'b0;
        tick(10);
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL blk_inc_running: pulses=%0d want 0", pulses);
        end
        press_mode();
        total++;
        if (outs() !== O_ALARM) begin
            bad++;
            $display("FAIL blk_mode_clears_run: got %b want %b", outs(), O_ALARM);
        end
        $display("txn inc_blocked pulses=%0d outs=%b", pulses, outs());
    endtask

    task automatic test_simultaneous();
        int run_seen;
        press_mode();
        press_mode();
        press_mode();
        press_mode();
        total++;
        if (outs() !== O_TIMER) begin
            bad++;
            $display("FAIL sim_setup_timer: got %b want %b", outs(), O_TIMER);
        end
        run_seen = 0;
        btn_mode = 1'b1;
        btn_go = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (timercount === 1'b1 || alarmcount === 1'b1) run_seen++;
        end
        btn_mode = 1'b0;
        btn_go = 1'b0;
        tick(10);
        total++;
        if (outs() !== O_ALARM || run_seen != 0) begin
            bad++;
            $display("FAIL sim_mode_wins: got %b run_seen=%0d want %b run_seen=0", outs(), run_seen, O_ALARM);
        end
        $display("txn simultaneous outs=%b", outs());
    endtask

    task automatic test_reset_mid_op();
        press_mode();
        press_mode();
        press_mode();
        total++;
        if (outs() !== O_DOWN) begin
            bad++;
            $display("FAIL rst_setup_down: got %b want %b", outs(), O_DOWN);
        end
        btn_mode = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        total++;
        if (outs() !== O_CLOCK) begin
            bad++;
            $display("FAIL rst_mid_outs: got %b want %b", outs(), O_CLOCK);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            total++;
            if (outs() !== ((k >= 6) ? O_UP : O_CLOCK)) begin
                bad++;
                $display("FAIL rst_fresh_press_t%0d: got %b want %b", k, outs(), ((k >= 6) ? O_UP : O_CLOCK));
            end
        end
        btn_mode = 1'b0;
        tick(10);
        $display("txn reset_mid_op outs=%b", outs());
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_go_bounce();
        test_auto_repeat();
        test_inc_blocked_when_running();
        test_simultaneous();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
